// File: rtl/ifu_fetch_if.sv
// Instruction-memory fetch handshake.
// The fetch unit drives req/addr; memory answers with ready/rdata.
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// Fetch unit: PC register, ready-based fetch, next-PC select.
// One instruction per FETCH/EXEC pair; HALTED exits only via rst.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master imem,
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  input  logic [31:0] ext_imm,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misalign
);

  typedef enum logic [1:0] {
    BOOT, FETCH, EXEC, HALTED
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] instr_q, instr_n;
  logic        mis_q, mis_n;
  logic [31:0] npc;
  logic        req;
  logic        valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      instr_q <= instr_n;
      mis_q   <= mis_n;
    end
  end

  assign pc_plus4 = pc_q + 32'd4;

  // jr wins over j, j over a taken branch
  always_comb begin
    npc = pc_plus4;
    priority case (1'b1)
      jump_reg: npc = {reg_target[31:2], 2'b00};
      jump:     npc = {pc_plus4[31:28],
                       instr_q[25:0], 2'b00};
      branch:   npc = pc_plus4 + (ext_imm << 2);
      default:  npc = pc_plus4;
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    instr_n = instr_q;
    mis_n   = mis_q;
    req     = 1'b0;
    valid   = 1'b0;
    unique case (state)
      BOOT: state_n = FETCH;
      FETCH: begin
        req = 1'b1;
        if (imem.imem_ready) begin
          instr_n = imem.imem_rdata;
          state_n = EXEC;
        end
      end
      EXEC: begin
        valid = 1'b1;
        if (halt) begin
          state_n = HALTED;
        end else begin
          pc_n    = npc;
          state_n = FETCH;
          if (jump_reg && (|reg_target[1:0]))
            mis_n = 1'b1;
        end
      end
      HALTED: state_n = HALTED;
      default: state_n = BOOT;
    endcase
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign imm16          = instr_q[15:0];
  assign pc             = pc_q;
  assign instr_valid    = valid;
  assign misalign       = mis_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch.
// Expected fetch addresses are queued at EXEC and popped on request.
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        jump_reg = 1'b0;
  logic [31:0] reg_target = 32'h0;
  logic [31:0] ext_imm = 32'h0;
  logic        halt = 1'b0;
  logic [31:0] instr;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misalign;

  ifu_fetch_if bus ();

  ifu_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .branch      (branch),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .reg_target  (reg_target),
    .ext_imm     (ext_imm),
    .halt        (halt),
    .instr       (instr),
    .imm16       (imm16),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] q_exp[$];
  logic        m_mis = 1'b0;
  logic [31:0] last_word = 32'h0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_imm16", {16'h0, imm16}, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h3004);
    chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_mis", {31'h0, misalign}, 32'h0);
  endtask

  task automatic do_fetch(input int waits,
                          input logic [31:0] word,
                          input logic br, jp, jr, hl,
                          input logic [31:0] imm,
                          input logic [31:0] tgt);
    int          t;
    logic [31:0] a;
    logic [31:0] p4;
    logic [31:0] nxt;
    t = 0;
    while (!bus.imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.imem_req) begin
      chk("req_timeout", 32'h0, 32'h1);
      return;
    end
    if (q_exp.size() == 0) begin
      chk("sb_empty", bus.imem_addr, 32'hdead);
      return;
    end
    a = q_exp.pop_front();
    chk("fetch_addr", bus.imem_addr, a);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      @(negedge clk);
      chk("wait_req", {31'h0, bus.imem_req}, 32'h1);
      chk("wait_addr", bus.imem_addr, a);
      chk("wait_valid", {31'h0, instr_valid}, 32'h0);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    chk("exec_valid", {31'h0, instr_valid}, 32'h1);
    chk("exec_instr", instr, word);
    chk("exec_imm16", {16'h0, imm16}, {16'h0, word[15:0]});
    chk("exec_pc", pc, a);
    chk("exec_pc4", pc_plus4, a + 32'd4);
    bus.imem_ready = 1'b0;
    bus.imem_rdata = $urandom;
    branch = br;
    jump = jp;
    jump_reg = jr;
    halt = hl;
    ext_imm = imm;
    reg_target = tgt;
    p4 = a + 32'd4;
    if (jr) nxt = {tgt[31:2], 2'b00};
    else if (jp) nxt = {p4[31:28], word[25:0], 2'b00};
    else if (br) nxt = p4 + {imm[29:0], 2'b00};
    else nxt = p4;
    if (!hl) begin
      q_exp.push_back(nxt);
      if (jr && tgt[1:0] != 2'b00) m_mis = 1'b1;
    end
    last_word = word;
    @(negedge clk);
    branch = 1'b0;
    jump = 1'b0;
    jump_reg = 1'b0;
    halt = 1'b0;
    chk("post_valid", {31'h0, instr_valid}, 32'h0);
    chk("post_mis", {31'h0, misalign}, {31'h0, m_mis});
    chk("post_instr", instr, word);
  endtask

  task automatic restart();
    q_exp.delete();
    q_exp.push_back(32'h3000);
    m_mis = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("boot_req", {31'h0, bus.imem_req}, 32'h0);
    @(negedge clk);
    chk("c1_req", {31'h0, bus.imem_req}, 32'h1);
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    #12;
    chk_reset();
    restart();
    do_fetch(0, 32'h2001_0001, 0, 0, 0, 0, 0, 0);
    do_fetch(3, 32'h2002_0002, 0, 0, 0, 0, 0, 0);
    do_fetch(0, 32'h2003_0003, 0, 0, 0, 0, 0, 0);
    do_fetch(1, 32'h2004_0004, 0, 0, 0, 0, 0, 0);
    do_fetch(0, 32'h1000_fffe, 1, 0, 0, 0,
             32'hffff_fffe, 0);
    do_fetch(0, 32'h2005_0005, 0, 0, 0, 0, 0, 0);
    do_fetch(2, 32'h1000_ffff, 1, 0, 0, 0,
             32'hffff_ffff, 0);
    do_fetch(0, 32'h0800_0c10, 1, 1, 0, 0,
             32'h0000_0005, 0);
    do_fetch(0, 32'h0800_0c10, 1, 1, 1, 0,
             32'h0000_0005, 32'h0000_3007);
    do_fetch(0, 32'h2006_0006, 0, 0, 0, 0, 0, 0);
    do_fetch(0, 32'h2007_0007, 0, 0, 0, 1, 0, 0);
    chk("sb_drained", q_exp.size(), 32'h0);
    branch = 1'b1;
    jump = 1'b1;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_req", {31'h0, bus.imem_req}, 32'h0);
      chk("halt_pc", pc, 32'h3008);
      chk("halt_valid", {31'h0, instr_valid}, 32'h0);
      chk("halt_instr", instr, last_word);
    end
    branch = 1'b0;
    jump = 1'b0;
    bus.imem_ready = 1'b0;
    chk("halt_mis", {31'h0, misalign}, 32'h1);
    rst = 1'b1;
    #1;
    chk_reset();
    restart();
    do_fetch(0, 32'h2008_0008, 0, 0, 1, 0, 0,
             32'h0000_3011);
    do_fetch(0, 32'h2009_0009, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_req", {31'h0, bus.imem_req}, 32'h1);
    bus.imem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset();
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hbad0_bad0;
    @(posedge clk);
    #1;
    chk_reset();
    bus.imem_ready = 1'b0;
    restart();
    do_fetch(0, 32'h200a_000a, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1, "timeout");
  end
endmodule
